// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if -- signal bundle between a PRBS receive path and lfsr_checker.
//   master: drives in_bit, in_valid, clr_err; observes the status outputs.
//   slave : the checker; observes the inputs; drives locked, err_pulse,
//           err_count[ERR_W-1:0], sync_state[1:0], exp_bit.
interface lfsr_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             in_bit;
  logic             in_valid;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       sync_state;
  logic             exp_bit;

  modport master (
    output in_bit, in_valid, clr_err,
    input  locked, err_pulse, err_count, sync_state, exp_bit
  );

  modport slave (
    input  in_bit, in_valid, clr_err,
    output locked, err_pulse, err_count, sync_state, exp_bit
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker -- self-synchronising checker for the 4-bit PRBS stream
// (b[n+4] = b[n] ^ b[n+1], period 15).
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : lfsr_checker_if.slave
//            in_bit/in_valid : serial bit, accepted when in_valid is high
//            clr_err         : synchronous clear of err_count
//            locked          : high in LOCKED
//            err_pulse       : one-cycle pulse per counted error
//            err_count       : saturating error count (LOCKED only)
//            sync_state      : 00 HUNT, 01 VERIFY, 10 LOCKED
//            exp_bit         : prediction of the next bit from the shadow
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input logic           clk,
  input logic           reset,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  state_t           state, state_n;
  logic [3:0]       h, h_n;          // h[3] newest, h[0] oldest
  logic [2:0]       fill_cnt, fill_n;
  logic [3:0]       good_cnt, good_n;
  logic [3:0]       bad_run, bad_n;
  logic [ERR_W-1:0] err_count, err_n;
  logic             err_pulse, pulse_n;
  logic             exp_bit;
  logic             match;
  logic [3:0]       h_shift_in;

  assign exp_bit    = h[0] ^ h[1];
  assign match      = (bus.in_bit == exp_bit);
  assign h_shift_in = {bus.in_bit, h[3:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      h         <= '0;
      fill_cnt  <= '0;
      good_cnt  <= '0;
      bad_run   <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill_cnt  <= fill_n;
      good_cnt  <= good_n;
      bad_run   <= bad_n;
      err_count <= err_n;
      err_pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    h_n     = h;
    fill_n  = fill_cnt;
    good_n  = good_cnt;
    bad_n   = bad_run;
    err_n   = err_count;
    pulse_n = 1'b0;

    if (bus.in_valid) begin
      unique case (state)
        HUNT: begin
          h_n = h_shift_in;
          if (fill_cnt != 3'd4) fill_n = fill_cnt + 3'd1;
          // Four bits gathered (including this one) and a legal seed seen.
          if ((fill_cnt == 3'd3 || fill_cnt == 3'd4) && (h_shift_in != '0)) begin
            state_n = VERIFY;
            good_n  = '0;
          end
        end
        VERIFY: begin
          h_n = h_shift_in;
          if (match) begin
            good_n = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_C) begin
              state_n = LOCKED;
              bad_n   = '0;
            end
          end else begin
            state_n = HUNT;
            fill_n  = '0;
            h_n     = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the shadow follows its own prediction so isolated
          // channel errors do not corrupt the reference.
          h_n = {exp_bit, h[3:1]};
          if (match) begin
            bad_n = '0;
          end else begin
            pulse_n = 1'b1;
            if (err_count != '1) err_n = err_count + 1'b1;
            bad_n = bad_run + 4'd1;
            if (bad_run + 4'd1 == LOSS_C) begin
              state_n = HUNT;
              fill_n  = '0;
              h_n     = '0;
            end
          end
        end
        default: begin
          state_n = HUNT;
          fill_n  = '0;
          h_n     = '0;
        end
      endcase
    end

    if (bus.clr_err) err_n = '0;
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.sync_state = state;
  assign bus.err_pulse  = err_pulse;
  assign bus.err_count  = err_count;
  assign bus.exp_bit    = exp_bit;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial receiver/checker for the 4-bit PRBS stream produced by the team's LFSR generator (lfsr_struct), taking the generator's state[0] as the serial bit each clock.
- Self-synchronises by loading its shadow register from received bits, then verifies, locks and counts bit errors.
- Sits at the receive end of the test/BIST link, after any serial channel, and reports lock status and error statistics to the host.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in VERIFY needed to declare lock (1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED needed to drop lock (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bit  input  1  received serial bit.
- in_valid  input  1  in_bit is accepted on this edge when high; nothing advances when low.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per bit error counted in LOCKED.
- err_count  output  ERR_W  saturating count of errors seen in LOCKED.
- sync_state  output  2  FSM state: 00 HUNT, 01 VERIFY, 10 LOCKED.
- exp_bit  output  1  predicted value of the next bit (combinational from h).

Behaviour:
- Sequence law: b[n+4] = b[n] XOR b[n+1], period 15, never all-zero.
- Shadow history h[3:0]: h[3] is the newest accepted bit, h[0] the oldest. Shift on accept: h <= {new, h[3:1]}. exp_bit = h[0] XOR h[1].
- Reset: state HUNT; h=0; fill_cnt=0; good_cnt=0; bad_run=0; err_count=0; err_pulse=0; locked=0.
- in_valid=0: all counters, h and state hold; err_pulse goes to 0.
- HUNT: every accepted bit shifts in in_bit. fill_cnt increments and saturates at 4.
  - If fill_cnt is 3 or 4 and the post-shift h is nonzero, go to VERIFY with good_cnt=0.
  - All-zero input therefore never leaves HUNT.
- VERIFY: each accepted bit shifts in in_bit.
  - Match with exp_bit: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED with bad_run=0.
  - Mismatch: go to HUNT with fill_cnt=0 and h=0. Not counted in err_count; no err_pulse.
- LOCKED (flywheel): each accepted bit shifts exp_bit into h, not in_bit.
  - Match: bad_run=0.
  - Mismatch: err_pulse=1 for the following cycle, err_count increments (saturates at all-ones), bad_run++.
  - When bad_run reaches LOSS_CNT: go to HUNT with fill_cnt=0, h=0, locked=0 on that edge. The error is still counted.
- Lock latency with continuous in_valid: locked rises on the edge accepting bit number 4+LOCK_CNT (12 with defaults).
- clr_err coinciding with an increment: clear wins, err_count=0. err_pulse is unaffected by clr_err.
- reset has priority over every other input. Reset mid-LOCKED returns to HUNT next edge with all outputs at reset values.
- Outputs locked, sync_state, err_pulse and err_count are registered.

Test Plan:
- Lock acquisition: reset, then continuous in_valid stream from seed 1000 (000100110101111 repeating) -> sync_state goes 00 → 01 after bit 4 → 10 after bit 12; locked=1; err_count stays 0 over 100 bits.
- Single error: after lock, invert bit 20 -> err_pulse high exactly one cycle; err_count=1; locked stays 1; the following correct bits produce no further errors (flywheel).
- Loss of lock: after lock, invert 3 consecutive bits -> err_count=3; locked falls on the 3rd error edge; relocks 12 accepted bits later.
- Degenerate input: 50 zero bits with in_valid=1 -> sync_state stays 00, locked=0. Then an error during VERIFY (flip bit 8) -> returns to HUNT and err_count stays 0.
- Valid gaps: same stream with in_valid toggling 1/0 -> lock after 12 accepted bits (about 24 cycles); h and counters hold on idle cycles.
- Counter edges: ERR_W=2, force 5 isolated errors -> err_count saturates at 3. clr_err on the same edge as an error -> err_count=0 with err_pulse=1. Reset while locked -> locked=0 and err_count=0 next edge.
